// File: rtl/sci_pkg.sv
`default_nettype none
// ---- sci_pkg : shared SCI state encodings, command bits and default widths (rev 1.0) ----
package sci_pkg;

  localparam int SCI_ADDR_WIDTH = 8;
  localparam int SCI_DATA_WIDTH = 8;

  localparam logic SCI_CMD_WRITE = 1'b1;
  localparam logic SCI_CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RDATA = 3'd5,
    ST_GAP   = 3'd6
  } sci_state_t;

  function automatic int sci_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sci_master_shifter.sv
`default_nettype none
// ---- sci_master_shifter : loadable shift register, MSB-first out and MSB-first in (rev 1.0) ----
module sci_master_shifter
  import sci_pkg::*;
#(
  parameter int WIDTH    = SCI_ADDR_WIDTH + SCI_DATA_WIDTH,
  parameter int IN_WIDTH = SCI_DATA_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_load,
  input  logic [WIDTH-1:0]    i_load_data,
  input  logic                i_shift_out,
  input  logic                i_shift_in,
  input  logic                i_sdi,
  output logic                o_msb,
  output logic [IN_WIDTH-1:0] o_in_word
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_in_next;

  // o_in_word includes the bit being sampled now, so the last read bit is usable in the same cycle
  assign w_in_next = {r_q[WIDTH-2:0], i_sdi};
  assign o_msb     = r_q[WIDTH-1];
  assign o_in_word = w_in_next[IN_WIDTH-1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift_out) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end else if (i_shift_in) begin
      r_q <= w_in_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sci_master.sv
`default_nettype none
// ---- sci_master : parallel request/response to serial SCI command master (rev 1.0) ----
module sci_master
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH = SCI_ADDR_WIDTH,
  parameter int DATA_WIDTH = SCI_DATA_WIDTH,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WNR,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  CSN,
  output logic                  SDO,
  input  logic                  SDI,
  input  logic                  SACK
);

  localparam int SH_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(sci_max4(ADDR_WIDTH, DATA_WIDTH, TIMEOUT, GAP_CYCLES) + 1);

  localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] C_RD_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  sci_state_t             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_wnr;
  logic                   r_req_ready;
  logic                   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_rdata;
  logic                   r_rsp_err;
  logic                   r_csn;
  logic                   r_sdo;

  logic                   w_accept;
  logic                   w_shift_out;
  logic                   w_shift_in;
  logic                   w_sh_msb;
  logic [DATA_WIDTH-1:0]  w_in_word;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_fin;
  logic                   w_fin_err;
  logic [DATA_WIDTH-1:0]  w_fin_data;

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;
  assign CSN       = r_csn;
  assign SDO       = r_sdo;

  assign w_accept    = (r_state == ST_IDLE) && REQ_VALID && r_req_ready;
  assign w_shift_out = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_WDATA);
  assign w_shift_in  = ((r_state == ST_RWAIT) || (r_state == ST_RDATA)) && SACK;
  assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  sci_master_shifter #(
    .WIDTH    (SH_W),
    .IN_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .CLK         (CLK),
    .RST         (RST),
    .i_load      (w_accept),
    .i_load_data ({REQ_ADDR, REQ_WDATA}),
    .i_shift_out (w_shift_out),
    .i_shift_in  (w_shift_in),
    .i_sdi       (SDI),
    .o_msb       (w_sh_msb),
    .o_in_word   (w_in_word)
  );

  // Frame completion: write done, read done, read timeout or SACK abort
  always_comb begin
    w_fin      = 1'b0;
    w_fin_err  = 1'b0;
    w_fin_data = '0;
    case (r_state)
      ST_WDATA: w_fin = (r_cnt == C_DATA_LAST);
      ST_RWAIT: begin
        if (SACK && (DATA_WIDTH == 1)) begin
          w_fin      = 1'b1;
          w_fin_data = w_in_word;
        end else if (!SACK && (r_cnt == C_TO_LAST)) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      ST_RDATA: begin
        if (!SACK) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else if (r_cnt == C_RD_LAST) begin
          w_fin      = 1'b1;
          w_fin_data = w_in_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_wnr       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_csn       <= 1'b1;
      r_sdo       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_CMD;
            r_wnr       <= REQ_WNR;
            r_req_ready <= 1'b0;
            r_csn       <= 1'b0;
            r_sdo       <= REQ_WNR;
            r_cnt       <= '0;
          end
        end
        ST_CMD: begin
          r_state <= ST_ADDR;
          r_sdo   <= w_sh_msb;
          r_cnt   <= CNT_W'(1);
        end
        ST_ADDR: begin
          if (r_cnt == C_ADDR_LAST) begin
            if (r_wnr == SCI_CMD_WRITE) begin
              r_state <= ST_WDATA;
              r_sdo   <= w_sh_msb;
              r_cnt   <= CNT_W'(1);
            end else begin
              r_state <= ST_RWAIT;
              r_sdo   <= 1'b0;
              r_cnt   <= '0;
            end
          end else begin
            r_sdo <= w_sh_msb;
            r_cnt <= w_cnt_inc;
          end
        end
        ST_WDATA: begin
          r_sdo <= w_sh_msb;
          r_cnt <= w_cnt_inc;
        end
        ST_RWAIT: begin
          if (SACK) begin
            r_state <= ST_RDATA;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_RDATA: r_cnt <= w_cnt_inc;
        ST_GAP: begin
          if (r_cnt == C_GAP_LAST) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_csn       <= 1'b1;
          r_sdo       <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
      // Any frame end overrides the per-state update: respond and release CSN
      if (w_fin) begin
        r_state     <= ST_GAP;
        r_cnt       <= '0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_fin_err;
        r_rsp_rdata <= w_fin_data;
        r_csn       <= 1'b1;
        r_sdo       <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sci_master.sv
`default_nettype none
// ---- tb_sci_master : directed bench for sci_master with a behavioural SCI slave and register model (rev 1.0) ----
module tb_sci_master;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_WNR = 1'b0;
  logic [7:0] REQ_ADDR = 8'h00;
  logic [7:0] REQ_WDATA = 8'h00;
  logic       REQ_READY, RSP_VALID, RSP_ERR, CSN, SDO;
  logic [7:0] RSP_RDATA;
  logic       SDI, SACK;

  int checks = 0;
  int failures = 0;

  sci_master #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .GAP_CYCLES (1),
    .TIMEOUT    (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WNR   (REQ_WNR),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .CSN       (CSN),
    .SDO       (SDO),
    .SDI       (SDI),
    .SACK      (SACK)
  );

  always #5 CLK = ~CLK;

  // Behavioural SCI slave + register file; read data valid 3 cycles after the read request
  logic [16:0] s_bits;
  logic [16:0] s_nxt;
  logic [4:0]  s_n;
  logic [2:0]  s_wait;
  logic [3:0]  s_sack_left;
  logic [7:0]  s_rd, s_raddr;
  logic [7:0]  mem [256];
  int          wreq_cnt = 0;
  logic [7:0]  last_waddr = 8'h00;
  logic [7:0]  last_wdata = 8'h00;
  logic        no_rvalid = 1'b0;
  int          sack_len = 8;

  assign s_nxt = {s_bits[15:0], SDO};

  always @(posedge CLK or posedge RST) begin
    if (RST || CSN) begin
      s_bits      <= '0;
      s_n         <= '0;
      s_wait      <= '0;
      s_sack_left <= '0;
      SACK        <= 1'b0;
      SDI         <= 1'b0;
    end else begin
      if (s_n < 17) begin
        s_bits <= s_nxt;
        s_n    <= s_n + 5'd1;
      end
      if (s_n == 8 && s_nxt[8] == 1'b0) begin
        s_raddr <= s_nxt[7:0];
        s_wait  <= 3'd3;
      end
      if (s_n == 16 && s_nxt[16] == 1'b1) begin
        mem[s_nxt[15:8]] <= s_nxt[7:0];
        wreq_cnt   <= wreq_cnt + 1;
        last_waddr <= s_nxt[15:8];
        last_wdata <= s_nxt[7:0];
      end
      if (s_wait != 0) begin
        s_wait <= s_wait - 3'd1;
        if (s_wait == 3'd1 && !no_rvalid) begin
          s_rd        <= mem[s_raddr];
          s_sack_left <= sack_len[3:0];
        end
      end
      if (s_sack_left != 0) begin
        SACK        <= 1'b1;
        SDI         <= s_rd[7];
        s_rd        <= {s_rd[6:0], 1'b0};
        s_sack_left <= s_sack_left - 4'd1;
      end else begin
        SACK <= 1'b0;
        SDI  <= 1'b0;
      end
    end
  end

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({CSN, SDO, REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_in got=%b exp=%b", {CSN, SDO, REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA}, 13'b1010000000000);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({CSN, SDO, REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_after got=%b exp=%b", {CSN, SDO, REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA}, 13'b1010000000000);
    end
  endtask

  task automatic test_write(input logic [7:0] a, input logic [7:0] d);
    logic [16:0] sdo_v;
    int csn_hi, rv_seen, wc0;
    sdo_v = '0; csn_hi = 0; rv_seen = 0; wc0 = wreq_cnt;
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1) begin failures++; $display("FAIL wr_ready_idle got=%b exp=1", REQ_READY); end
    REQ_WNR = 1'b1; REQ_ADDR = a; REQ_WDATA = d; REQ_VALID = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        REQ_VALID = 1'b0;
        checks++;
        if (REQ_READY !== 1'b0) begin failures++; $display("FAIL wr_ready_busy got=%b exp=0", REQ_READY); end
      end
      sdo_v = {sdo_v[15:0], SDO};
      if (CSN !== 1'b0) csn_hi++;
      if (RSP_VALID !== 1'b0) rv_seen++;
    end
    checks++;
    if (sdo_v !== {1'b1, a, d}) begin failures++; $display("FAIL wr_sdo got=%h exp=%h", sdo_v, {1'b1, a, d}); end
    checks++;
    if (csn_hi != 0) begin failures++; $display("FAIL wr_csn_low high_cycles=%0d exp=0", csn_hi); end
    checks++;
    if (rv_seen != 0) begin failures++; $display("FAIL wr_early_rsp got=%0d exp=0", rv_seen); end
    @(negedge CLK);
    checks++;
    if ({CSN, RSP_VALID, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL wr_rsp got csn/valid/err/rdata=%b%b%b/%h exp=110/00", CSN, RSP_VALID, RSP_ERR, RSP_RDATA);
    end
    checks++;
    if (wreq_cnt != wc0 + 1 || last_waddr !== a || last_wdata !== d) begin
      failures++;
      $display("FAIL wr_slave got n=%0d addr=%h data=%h exp n=%0d addr=%h data=%h", wreq_cnt - wc0, last_waddr, last_wdata, 1, a, d);
    end
    @(negedge CLK);
    checks++;
    if ({REQ_READY, RSP_VALID} !== 2'b10) begin failures++; $display("FAIL wr_ready_after got=%b exp=10", {REQ_READY, RSP_VALID}); end
  endtask

  task automatic test_read(input logic [7:0] a, input logic [7:0] exp_d);
    logic [8:0] sdo_v;
    int sacks, got;
    sdo_v = '0; sacks = 0; got = 0;
    @(negedge CLK);
    REQ_WNR = 1'b0; REQ_ADDR = a; REQ_WDATA = 8'hFF; REQ_VALID = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge CLK);
      if (i == 1) REQ_VALID = 1'b0;
      sdo_v = {sdo_v[7:0], SDO};
    end
    checks++;
    if (sdo_v !== {1'b0, a}) begin failures++; $display("FAIL rd_sdo got=%h exp=%h", sdo_v, {1'b0, a}); end
    for (int i = 10; i <= 60 && got == 0; i++) begin
      @(negedge CLK);
      if (RSP_VALID === 1'b1) got = 1;
      else if (SACK === 1'b1) sacks++;
    end
    checks++;
    if (got != 1) begin failures++; $display("FAIL rd_timeout_wait got=%0d exp=1", got); end
    checks++;
    if (sacks != 8) begin failures++; $display("FAIL rd_sack_cycles got=%0d exp=8", sacks); end
    checks++;
    if ({CSN, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b0, exp_d}) begin
      failures++;
      $display("FAIL rd_rsp got csn/err/rdata=%b%b/%h exp=10/%h", CSN, RSP_ERR, RSP_RDATA, exp_d);
    end
    @(negedge CLK);
    checks++;
    if ({RSP_VALID, RSP_RDATA} !== {1'b0, exp_d}) begin
      failures++;
      $display("FAIL rd_hold got valid/rdata=%b/%h exp=0/%h", RSP_VALID, RSP_RDATA, exp_d);
    end
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1) begin failures++; $display("FAIL rd_ready_after got=%b exp=1", REQ_READY); end
  endtask

  task automatic test_abort();
    int sacks, last_sack, rsp_i;
    sacks = 0; last_sack = 0; rsp_i = 0;
    sack_len = 4;
    @(negedge CLK);
    REQ_WNR = 1'b0; REQ_ADDR = 8'h3C; REQ_VALID = 1'b1;
    for (int i = 1; i <= 60 && rsp_i == 0; i++) begin
      @(negedge CLK);
      if (i == 1) REQ_VALID = 1'b0;
      if (RSP_VALID === 1'b1) rsp_i = i;
      else if (SACK === 1'b1) begin sacks++; last_sack = i; end
    end
    checks++;
    if (sacks != 4) begin failures++; $display("FAIL ab_sack_cycles got=%0d exp=4", sacks); end
    checks++;
    if (rsp_i != last_sack + 2) begin failures++; $display("FAIL ab_latency got=%0d exp=%0d", rsp_i, last_sack + 2); end
    checks++;
    if ({CSN, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL ab_rsp got csn/err/rdata=%b%b/%h exp=11/00", CSN, RSP_ERR, RSP_RDATA);
    end
    @(negedge CLK);
    checks++;
    if ({REQ_READY, CSN, RSP_VALID} !== 3'b110) begin failures++; $display("FAIL ab_ready_after got=%b exp=110", {REQ_READY, CSN, RSP_VALID}); end
    sack_len = 8;
  endtask

  task automatic test_back_to_back();
    int first_ready, wr_rsp_i, got;
    first_ready = 0; wr_rsp_i = 0; got = 0;
    @(negedge CLK);
    REQ_WNR = 1'b1; REQ_ADDR = 8'h10; REQ_WDATA = 8'h01; REQ_VALID = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge CLK);
      if (i == 1) begin REQ_WNR = 1'b0; REQ_ADDR = 8'h10; REQ_WDATA = 8'h00; end
      if (RSP_VALID === 1'b1 && wr_rsp_i == 0) wr_rsp_i = i;
      if (REQ_READY === 1'b1 && first_ready == 0) first_ready = i;
    end
    checks++;
    if (wr_rsp_i != 18) begin failures++; $display("FAIL b2b_wr_rsp_cycle got=%0d exp=18", wr_rsp_i); end
    checks++;
    if (first_ready != 19) begin failures++; $display("FAIL b2b_accept_cycle got=%0d exp=19", first_ready); end
    @(negedge CLK);
    REQ_VALID = 1'b0;
    checks++;
    if ({REQ_READY, CSN, SDO} !== 3'b000) begin failures++; $display("FAIL b2b_second_cmd got=%b exp=000", {REQ_READY, CSN, SDO}); end
    for (int i = 0; i < 60 && got == 0; i++) begin
      @(negedge CLK);
      if (RSP_VALID === 1'b1) got = 1;
    end
    checks++;
    if (got != 1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 8'h01) begin
      failures++;
      $display("FAIL b2b_read got seen/err/rdata=%0d/%b/%h exp=1/0/01", got, RSP_ERR, RSP_RDATA);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_timeout();
    int rsp_i;
    logic csn_before;
    rsp_i = 0; csn_before = 1'b1;
    no_rvalid = 1'b1;
    @(negedge CLK);
    REQ_WNR = 1'b0; REQ_ADDR = 8'h22; REQ_VALID = 1'b1;
    for (int i = 1; i <= 40 && rsp_i == 0; i++) begin
      @(negedge CLK);
      if (i == 1) REQ_VALID = 1'b0;
      if (i == 25) csn_before = CSN;
      if (RSP_VALID === 1'b1) rsp_i = i;
    end
    checks++;
    if (rsp_i != 26) begin failures++; $display("FAIL to_cycle got=%0d exp=26", rsp_i); end
    checks++;
    if (csn_before !== 1'b0) begin failures++; $display("FAIL to_csn_wait got=%b exp=0", csn_before); end
    checks++;
    if ({CSN, RSP_ERR, RSP_RDATA} !== {1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL to_rsp got csn/err/rdata=%b%b/%h exp=11/00", CSN, RSP_ERR, RSP_RDATA);
    end
    @(negedge CLK);
    checks++;
    if (REQ_READY !== 1'b1) begin failures++; $display("FAIL to_ready_after got=%b exp=1", REQ_READY); end
    no_rvalid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int rv_seen, wc0;
    rv_seen = 0; wc0 = wreq_cnt;
    @(negedge CLK);
    REQ_WNR = 1'b1; REQ_ADDR = 8'hC3; REQ_WDATA = 8'h77; REQ_VALID = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      if (i == 1) REQ_VALID = 1'b0;
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({CSN, REQ_READY, RSP_VALID} !== 3'b110) begin failures++; $display("FAIL mid_async got=%b exp=110", {CSN, REQ_READY, RSP_VALID}); end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (RSP_VALID !== 1'b0) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || wreq_cnt != wc0) begin
      failures++;
      $display("FAIL mid_no_rsp got rsp=%0d wreq=%0d exp=0/0", rv_seen, wreq_cnt - wc0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_write(8'h3C, 8'hA5);
    test_read(8'h3C, 8'hA5);
    test_abort();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    test_write(8'h3C, 8'h5A);
    test_read(8'h3C, 8'h5A);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
